// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       we;
    size_e      size;
    logic       is_unsigned;
    logic [1:0] lane;
  } stage_t;

  function automatic logic misaligned(input size_e size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load-path lane extraction: picks the addressed byte/half out of a word
// and sign- or zero-extends it to 32 bits.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  size_e       i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_ext_b;
  logic        w_ext_h;

  assign w_byte  = i_rdata[{i_lane, 3'b000} +: 8];
  // Halves are only legal on even lanes, so lane[1] alone selects the half.
  assign w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_ext_b = ~i_unsigned & w_byte[7];
  assign w_ext_h = ~i_unsigned & w_half[15];

  always_comb begin
    o_data = '0;
    unique case (i_size)
      SZ_BYTE: o_data = {{24{w_ext_b}}, w_byte};
      SZ_HALF: o_data = {{16{w_ext_h}}, w_half};
      SZ_WORD: o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-ported data memory with byte/half/word access, fixed response
// latency, error detection and a non-blocking request interface.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DMSIZE      = 1024,
  parameter logic [31:0] BASEADDRESS = 32'h0000_0000,
  parameter int          RDLATENCY   = 1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_I,
  output logic        RSP_VALID,
  output logic [31:0] DATA_O,
  output logic        RSP_ERR
);

  localparam int          AW      = $clog2(DMSIZE);
  localparam logic [32:0] BASE33  = {1'b0, BASEADDRESS};
  localparam logic [32:0] LIMIT33 = BASE33 + 33'(4 * DMSIZE);

  logic [32:0]   w_addr33;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  size_e         w_size;
  logic [1:0]    w_lane;
  logic          w_err;
  logic          w_accept;
  logic          w_wr;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  stage_t        w_stage_in;

  // 33-bit compare so a window ending at 2^32 does not wrap.
  assign w_addr33   = {1'b0, ADDR};
  assign w_in_range = (w_addr33 >= BASE33) && (w_addr33 < LIMIT33);
  assign w_idx      = AW'((ADDR - BASEADDRESS) >> 2);
  assign w_size     = size_e'(REQ_SIZE);
  assign w_lane     = ADDR[1:0];
  assign w_err      = !w_in_range || (w_size == SZ_RSVD) || misaligned(w_size, w_lane);
  assign w_accept   = REQ_VALID && !ARESET;
  assign w_wr       = w_accept && REQ_WE && !w_err;
  assign w_be       = byte_en(w_size, w_lane) & {4{w_wr}};

  always_comb begin
    w_wdata = DATA_I;
    unique case (w_size)
      SZ_BYTE: w_wdata = {4{DATA_I[7:0]}};
      SZ_HALF: w_wdata = {2{DATA_I[15:0]}};
      default: w_wdata = DATA_I;
    endcase
  end

  always_comb begin
    w_stage_in             = '0;
    w_stage_in.valid       = w_accept;
    w_stage_in.err         = w_err;
    w_stage_in.we          = REQ_WE;
    w_stage_in.size        = w_size;
    w_stage_in.is_unsigned = REQ_UNSIGNED;
    w_stage_in.lane        = w_lane;
  end

  logic [31:0] r_mem [DMSIZE];
  logic [31:0] r_rdata;

  // Read and write share the accept edge; the read sees the old word.
  always_ff @(posedge ACLK) begin
    if (w_accept) r_rdata <= r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  stage_t r_stg [RDLATENCY];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < RDLATENCY; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= w_stage_in;
      for (int i = 1; i < RDLATENCY; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  logic [31:0] w_out_data;
  stage_t      w_out;

  generate
    if (RDLATENCY == 1) begin : g_lat1
      assign w_out_data = r_rdata;
    end else begin : g_latn
      logic [31:0] r_dpipe [RDLATENCY-1];
      always_ff @(posedge ACLK) begin
        r_dpipe[0] <= r_rdata;
        for (int i = 1; i < RDLATENCY - 1; i++) r_dpipe[i] <= r_dpipe[i-1];
      end
      assign w_out_data = r_dpipe[RDLATENCY-2];
    end
  endgenerate

  assign w_out = r_stg[RDLATENCY-1];

  logic [31:0] w_load_data;
  logic        w_rsp;

  dmem_lane_align u_align (
    .i_rdata    (w_out_data),
    .i_size     (w_out.size),
    .i_lane     (w_out.lane),
    .i_unsigned (w_out.is_unsigned),
    .o_data     (w_load_data)
  );

  // Gating with ARESET silences responses in the very cycle reset rises.
  assign w_rsp     = w_out.valid && !ARESET;
  assign REQ_READY = !ARESET;
  assign RSP_VALID = w_rsp;
  assign RSP_ERR   = w_rsp && w_out.err;
  assign DATA_O    = (w_rsp && !w_out.err && !w_out.we) ? w_load_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: one stimulus stream drives three controllers built with
// response latencies 1, 2 and 4; a reference memory predicts every response.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] DATA_I = 32'h0;

  logic        rdy  [3];
  logic        vld  [3];
  logic        err  [3];
  logic [31:0] dout [3];

  always #5 ACLK = ~ACLK;

  dmem_ctrl #(.DMSIZE(DEPTH), .BASEADDRESS(BASE), .RDLATENCY(1)) u_lat1 (
    .ACLK(ACLK), .ARESET(ARESET), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[0]),
    .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .ADDR(ADDR), .DATA_I(DATA_I), .RSP_VALID(vld[0]), .DATA_O(dout[0]), .RSP_ERR(err[0]));

  dmem_ctrl #(.DMSIZE(DEPTH), .BASEADDRESS(BASE), .RDLATENCY(2)) u_lat2 (
    .ACLK(ACLK), .ARESET(ARESET), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[1]),
    .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .ADDR(ADDR), .DATA_I(DATA_I), .RSP_VALID(vld[1]), .DATA_O(dout[1]), .RSP_ERR(err[1]));

  dmem_ctrl #(.DMSIZE(DEPTH), .BASEADDRESS(BASE), .RDLATENCY(4)) u_lat4 (
    .ACLK(ACLK), .ARESET(ARESET), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[2]),
    .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .ADDR(ADDR), .DATA_I(DATA_I), .RSP_VALID(vld[2]), .DATA_O(dout[2]), .RSP_ERR(err[2]));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [3][$];
  logic [31:0] mdl [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic        bad;
    int          idx;
    int          sh;
    logic [31:0] w;
    @(negedge ACLK);
    ARESET       = 1'b0;
    REQ_VALID    = 1'b1;
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    ADDR         = addr;
    DATA_I       = data;
    bad = (size == 2'b11) || (longint'(addr) < longint'(BASE)) ||
          (longint'(addr) >= longint'(BASE) + 4 * DEPTH) ||
          ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
    e.err  = bad;
    e.data = 32'h0;
    if (!bad) begin
      idx = int'((addr - BASE) >> 2);
      sh  = 8 * int'(addr[1:0]);
      w   = mdl[idx];
      if (we) begin
        case (size)
          2'b00:   w[sh +: 8]  = data[7:0];
          2'b01:   w[sh +: 16] = data[15:0];
          default: w = data;
        endcase
        mdl[idx] = w;
      end else begin
        case (size)
          2'b00:   e.data = uns ? {24'h0, w[sh +: 8]}  : {{24{w[sh+7]}}, w[sh +: 8]};
          2'b01:   e.data = uns ? {16'h0, w[sh +: 16]} : {{16{w[sh+15]}}, w[sh +: 16]};
          default: e.data = w;
        endcase
      end
    end
    for (int k = 0; k < 3; k++) begin
      e.due = cyc + lat_of(k);
      sb[k].push_back(e);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      assert (rdy[k] === 1'b1) else begin
        miscompares++;
        $error("FAIL lat%0d req_ready: got %b want 1", lat_of(k), rdy[k]);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ACLK);
      REQ_VALID = 1'b0;
    end
  endtask

  task automatic reset_pulse(input int n);
    @(negedge ACLK);
    ARESET    = 1'b1;
    REQ_VALID = 1'b0;
    for (int k = 0; k < 3; k++) sb[k].delete();
    repeat (n - 1) @(negedge ACLK);
  endtask

  always @(negedge ACLK) begin
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ARESET) begin
        vectors++;
        assert (rdy[k] === 1'b0) else begin
          miscompares++;
          $error("FAIL lat%0d ready_in_reset: got %b want 0", lat_of(k), rdy[k]);
        end
      end
      if (sb[k].size() > 0) begin
        vectors++;
        assert (sb[k][0].due >= cyc) else begin
          miscompares++;
          $error("FAIL lat%0d missing_rsp: due cycle %0d, now %0d", lat_of(k), sb[k][0].due, cyc);
          void'(sb[k].pop_front());
        end
      end
      if (vld[k] === 1'b1) begin
        vectors++;
        assert (sb[k].size() > 0) else begin
          miscompares++;
          $error("FAIL lat%0d unexpected_rsp: got rsp_valid at cycle %0d want none", lat_of(k), cyc);
        end
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          vectors++;
          assert (cyc == e.due) else begin
            miscompares++;
            $error("FAIL lat%0d latency: got cycle %0d want %0d", lat_of(k), cyc, e.due);
          end
          vectors++;
          assert ({err[k], dout[k]} === {e.err, e.data}) else begin
            miscompares++;
            $error("FAIL lat%0d rsp: got err=%b data=%h want err=%b data=%h",
                   lat_of(k), err[k], dout[k], e.err, e.data);
          end
        end
      end else begin
        vectors++;
        assert ({vld[k], err[k], dout[k]} === 34'h0) else begin
          miscompares++;
          $error("FAIL lat%0d idle_outputs: got vld=%b err=%b data=%h want all zero",
                 lat_of(k), vld[k], err[k], dout[k]);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge ACLK);

    issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h8081_82F3);
    issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h1000, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    idle(3);

    issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'h1111_1111);
    issue(1'b1, 2'b00, 1'b0, 32'h1005, 32'hABCD_EF5A);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h1006, 32'h1234_BEEF);
    issue(1'b0, 2'b01, 1'b1, 32'h1006, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hCAFE_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0);
    idle(2);

    issue(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h1001, 32'h0000_FFFF);
    issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'hDEAD_BEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEAD_BEEF);
    issue(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h1004, 32'h5555_5555);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0);
    idle(2);

    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'b10, 1'b0, 32'h1010, 32'h0101_0101 * (i + 1));
      issue(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);
    end
    idle(2);

    for (int i = 0; i < 8; i++) issue(1'b1, 2'b10, 1'b0, 32'h1020 + 4 * i, $urandom);
    for (int i = 0; i < 40; i++) begin
      a = 32'h1020 + 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle(2);

    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    reset_pulse(3);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h1006, 32'h0);
    idle(8);

    for (int k = 0; k < 3; k++) begin
      vectors++;
      assert (sb[k].size() == 0) else begin
        miscompares++;
        $error("FAIL lat%0d drain: got %0d pending want 0", lat_of(k), sb[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DMSIZE, default 1024, memory depth in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter BASEADDRESS, default 32'h0000_0000, byte address of word 0 (4-byte aligned).
REQ-003 SHALL have parameter RDLATENCY, default 1, accept-to-response latency in cycles (legal range 1..4).
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports are listed in REQ-005..REQ-016.
REQ-005 ACLK  input  1  sole clock, rising edge.
REQ-006 ARESET  input  1  synchronous active-high reset.
REQ-007 REQ_VALID  input  1  request present.
REQ-008 REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are both high at a rising edge.
REQ-009 REQ_WE  input  1  1 = store, 0 = load.
REQ-010 REQ_SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 REQ_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 ADDR  input  32  byte address.
REQ-013 DATA_I  input  32  store data, right-justified.
REQ-014 RSP_VALID  output  1  response pulse, one cycle per accepted request.
REQ-015 DATA_O  output  32  load result, right-justified and extended.
REQ-016 RSP_ERR  output  1  response carries an error.

Function
REQ-017 REQ_READY SHALL be 1 in every cycle in which ARESET is low; the block never back-pressures.
REQ-018 Word index SHALL be (ADDR - BASEADDRESS) >> 2; byte lane is ADDR[1:0].
REQ-019 A request SHALL be in range iff BASEADDRESS <= ADDR < BASEADDRESS + 4*DMSIZE, compared in 33-bit arithmetic so there is no wrap at 2^32.
REQ-020 A request SHALL be misaligned if it is a half access with ADDR[0]=1, or a word access with ADDR[1:0]!=0.
REQ-021 A request SHALL be an error if it is out of range, misaligned, or has REQ_SIZE=11.
REQ-022 An accepted store without error SHALL update only the addressed byte lanes at the accept edge; the other lanes are retained.
REQ-023 An erroneous store SHALL leave memory unchanged.
REQ-024 A store SHALL take byte data from DATA_I[7:0] and half data from DATA_I[15:0], replicated to the addressed lane.
REQ-025 A load SHALL read the word at the accept edge and deliver the addressed lane, extended per REQ_UNSIGNED.
REQ-026 Each accepted request, load or store, SHALL raise RSP_VALID exactly RDLATENCY cycles after the accept edge; responses stay in order.
REQ-027 Back-to-back accepts SHALL be sustained at one per cycle, so up to RDLATENCY requests are in flight.
REQ-028 A load accepted in the cycle after a store to the same word SHALL return the stored data.
REQ-029 Within a single request, read precedes write; a store response carries DATA_O=0.
REQ-030 On an error response, RSP_ERR=1 and DATA_O=0.
REQ-031 When RSP_VALID=0, DATA_O SHALL be 0 and RSP_ERR 0; the output is never tri-stated.
REQ-032 Memory contents are undefined until first written; no initialisation is required.

Reset
REQ-033 While ARESET=1: REQ_READY=0, RSP_VALID=0, DATA_O=0, RSP_ERR=0, and the pipeline valid bits are cleared.
REQ-034 Reset asserted mid-flight SHALL discard all in-flight responses; stores already committed remain in memory.
REQ-035 The first request SHALL be accepted at the first rising edge with ARESET low.

Structure
REQ-036 Package dmem_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and a pipeline-stage struct {valid, err, we, size, unsigned, lane}.
REQ-037 Sub-module dmem_lane_align SHALL perform combinational load extraction and extension; store lane masking stays in dmem_ctrl.
REQ-038 The storage array SHALL be a single synchronous-read array, 32 bits by DMSIZE, with per-byte write enables, inferable as block RAM.

Verification
REQ-039 Use BASEADDRESS=32'h1000, DMSIZE=1024, RDLATENCY=2. Store word 0x8081_82F3 @0x1000, then LB @0x1000 -> DATA_O=0xFFFF_FFF3 two cycles after accept; LBU -> 0x0000_00F3; LH @0x1002 -> 0xFFFF_8081.
REQ-040 Store byte 0x5A @0x1005 over word 0x1111_1111 @0x1004; LW @0x1004 -> 0x1111_5A11.
REQ-041 LW @0x1002, SH @0x1001, LW @0x2000, SW @0x0FFC, size=11 -> each gives RSP_ERR=1, DATA_O=0; memory is unchanged.
REQ-042 Eight back-to-back accepts (SW, LW alternating, same word, increasing data) -> eight in-order RSP_VALID pulses; each LW returns the preceding SW data.
REQ-043 Assert ARESET with two loads in flight -> no RSP_VALID that cycle or after; data stored before reset reads back correctly after release.
REQ-044 Repeat REQ-039 with RDLATENCY=1 and RDLATENCY=4 -> response latency matches the parameter exactly.
